// File: rtl/beamforming_pkg.sv
// Shared types and constants for the receive delay-and-sum beamformer.
// The BEAMFORMING_RECEIVE_CH_MASK_EN option is handled in the top module.
package beamforming_pkg;

    localparam int NUM_CH_DEF   = 8;
    localparam int SAMPLE_W_DEF = 8;
    localparam int DEPTH_DEF    = 32;
    localparam int DELAY_W_DEF  = $clog2(DEPTH_DEF);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ACCUM,
        DRAIN,
        DONE
    } rx_state_t;

    function automatic logic [DELAY_W_DEF-1:0] delay_field(
        input logic [NUM_CH_DEF*DELAY_W_DEF-1:0] cfg,
        input int                                ch
    );
        return cfg[ch*DELAY_W_DEF +: DELAY_W_DEF];
    endfunction

endpackage

// File: rtl/rx_delay_line.sv
// Single-channel circular sample buffer with a registered delayed tap.
// Delay 0 bypasses the memory and taps the incoming sample directly.
module rx_delay_line #(
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 32,
    parameter int DELAY_W  = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                wr_en,
    input  logic [DELAY_W-1:0]  wr_ptr,
    input  logic [DELAY_W-1:0]  delay,
    input  logic [SAMPLE_W-1:0] din,
    output logic [SAMPLE_W-1:0] tap
);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [DELAY_W-1:0]  rd_addr;

    assign rd_addr = wr_ptr - delay;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
            tap         <= (delay == '0) ? din : mem[rd_addr];
        end
    end

endmodule

// File: rtl/beamforming_receive.sv
// Receive delay-and-sum beamformer: per-channel delay lines, 2-stage sum.
// Optional macro BEAMFORMING_RECEIVE_CH_MASK_EN adds a per-channel mask.
module beamforming_receive
    import beamforming_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DELAY_W  = $clog2(DEPTH),
    parameter int SUM_W    = SAMPLE_W + $clog2(NUM_CH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [11:0]                  window_len,
    input  logic [NUM_CH*DELAY_W-1:0]    delay_cfg,
    input  logic                         sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
`ifdef BEAMFORMING_RECEIVE_CH_MASK_EN
    input  logic [NUM_CH-1:0]            ch_mask,
`endif
    output logic                         sum_valid,
    output logic [SUM_W-1:0]             sum_data,
    output logic                         busy,
    output logic                         done
);

    localparam logic [DELAY_W-1:0] FILL_LAST = DELAY_W'(DEPTH - 2);

    rx_state_t                  state, state_n;
    logic [DELAY_W-1:0]         wr_ptr, fill_cnt;
    logic [11:0]                len_q, out_cnt;
    logic [NUM_CH*DELAY_W-1:0]  dcfg_q;
    logic [NUM_CH-1:0]          mask_q;
    logic                       accept, v1;
    logic [SAMPLE_W-1:0]        taps [NUM_CH];
    logic [SUM_W-1:0]           acc;

    assign accept = start && (state == IDLE) && !busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rx_delay_line #(
            .SAMPLE_W (SAMPLE_W),
            .DEPTH    (DEPTH),
            .DELAY_W  (DELAY_W)
        ) u_dl (
            .clock  (clock),
            .wr_en  (sample_valid),
            .wr_ptr (wr_ptr),
            .delay  (delay_field(dcfg_q, i)),
            .din    (sample_data[i*SAMPLE_W +: SAMPLE_W]),
            .tap    (taps[i])
        );
    end

`ifdef BEAMFORMING_RECEIVE_CH_MASK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= '1;
        end else if (accept) begin
            mask_q <= ch_mask;
        end
    end
`else
    assign mask_q = '1;
`endif

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_q[i]) begin
                acc = acc + {{(SUM_W-SAMPLE_W){taps[i][SAMPLE_W-1]}}, taps[i]};
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (accept) state_n = (window_len == '0) ? DONE : FILL;
            FILL:  if (sample_valid && fill_cnt == FILL_LAST) state_n = ACCUM;
            ACCUM: if (sample_valid && out_cnt == len_q - 12'd1) state_n = DRAIN;
            DRAIN: state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // done is registered, so DRAIN plus DONE span the two pipeline stages
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            out_cnt   <= '0;
            len_q     <= '0;
            dcfg_q    <= '0;
            v1        <= 1'b0;
            sum_valid <= 1'b0;
            sum_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            v1        <= sample_valid && (state == ACCUM);
            sum_valid <= v1;
            done      <= (state == DONE);
            if (v1) sum_data <= acc;
            if (accept) busy <= 1'b1;
            else if (done) busy <= 1'b0;
            if (sample_valid) wr_ptr <= wr_ptr + 1'b1;
            if (accept) begin
                dcfg_q   <= delay_cfg;
                len_q    <= window_len;
                fill_cnt <= '0;
                out_cnt  <= '0;
            end else if (sample_valid) begin
                if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
                if (state == ACCUM) out_cnt <= out_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_beamforming_receive.sv
// Directed self-checking bench for beamforming_receive.
// Define BEAMFORMING_RECEIVE_CH_MASK_EN to also exercise the channel mask.
module tb_beamforming_receive;

    localparam int NCH  = 8;
    localparam int SW   = 8;
    localparam int DW   = 5;
    localparam int SUMW = 11;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              sample_valid = 1'b0;
    logic [11:0]       window_len = '0;
    logic [NCH*DW-1:0] delay_cfg = '0;
    logic [NCH*SW-1:0] sample_data = '0;
`ifdef BEAMFORMING_RECEIVE_CH_MASK_EN
    logic [NCH-1:0]    ch_mask = '1;
`endif
    logic              sum_valid, busy, done;
    logic [SUMW-1:0]   sum_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sq[$];
    int sc[$];
    int dq[$];
    int base, c0, s, nd;
    logic [NCH*DW-1:0] cfg;
    logic [NCH*SW-1:0] d;

    beamforming_receive dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .window_len   (window_len),
        .delay_cfg    (delay_cfg),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
`ifdef BEAMFORMING_RECEIVE_CH_MASK_EN
        .ch_mask      (ch_mask),
`endif
        .sum_valid    (sum_valid),
        .sum_data     (sum_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (sum_valid === 1'b1) begin
            sq.push_back(int'($signed(sum_data)));
            sc.push_back(cyc);
        end
        if (done === 1'b1) dq.push_back(cyc);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NCH*SW-1:0] rep(input logic [7:0] v);
        return {NCH{v}};
    endfunction

    function automatic int last_done();
        return (dq.size() == 0) ? -1 : dq[dq.size()-1];
    endfunction

    task automatic strobe(input logic [NCH*SW-1:0] v);
        sample_valid = 1'b1;
        sample_data  = v;
        tick();
    endtask

    task automatic arm(input logic [11:0] len, input logic [NCH*DW-1:0] c);
        start      = 1'b1;
        window_len = len;
        delay_cfg  = c;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && done !== 1'b1; i++) tick();
        chk(tag, done, 1);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 31; i++) strobe(rep(8'd0));
    endtask

    initial begin
        // reset and idle
        repeat (3) tick();
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum_data", sum_data, 0);
        reset = 1'b0;
        tick();

        // zero delays, window of 4, with an ignored start while busy
        arm(12'd4, '0);
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 31; i++) begin
            start      = (i == 5);
            window_len = (i == 5) ? 12'd7 : 12'd4;
            strobe(rep(8'd0));
        end
        start = 1'b0;
        base = sq.size();
        c0 = cyc;
        for (int j = 0; j < 4; j++) strobe(rep(8'd10));
        sample_valid = 1'b0;
        wait_done("zero_done_reached");
        // start coincident with done must be ignored
        start      = 1'b1;
        window_len = 12'd3;
        tick();
        start = 1'b0;
        chk("start_on_done_ignored", busy, 0);
        chk("zero_count", sq.size() - base, 4);
        for (int j = 0; j < 4 && base + j < sq.size(); j++) begin
            chk("zero_sum", sq[base+j], 80);
            chk("zero_lat", sc[base+j], c0 + 2 + j);
        end
        chk("zero_done_cycle", last_done(), c0 + 6);

        // staggered delays with an impulse at accum strobe 3
        for (int i = 0; i < NCH; i++) cfg[i*DW +: DW] = DW'(i);
        arm(12'd16, cfg);
        chk("start_after_done", busy, 1);
        fill_zero();
        base = sq.size();
        for (int j = 0; j < 16; j++) strobe((j == 3) ? rep(8'd64) : rep(8'd0));
        sample_valid = 1'b0;
        wait_done("stag_done_reached");
        tick();
        chk("stag_count", sq.size() - base, 16);
        for (int j = 0; j < 16 && base + j < sq.size(); j++)
            chk($sformatf("stag_out%0d", j), sq[base+j],
                (j >= 3 && j <= 10) ? 64 : 0);

        // maximum delay, pointer wraps, negative samples on ch0
        arm(12'd69, '1);
        base = sq.size();
        for (int n = 0; n < 100; n++) begin
            d = '0;
            d[7:0]  = 8'h80;
            d[15:8] = 8'(n);
            strobe(d);
        end
        sample_valid = 1'b0;
        wait_done("wrap_done_reached");
        tick();
        chk("wrap_count", sq.size() - base, 69);
        for (int j = 0; j < 69 && base + j < sq.size(); j++)
            chk($sformatf("wrap_out%0d", j), sq[base+j], -128 + j);

        // zero-length window
        tick();
        base = sq.size();
        nd = dq.size();
        s = cyc;
        arm(12'd0, '0);
        repeat (4) tick();
        chk("len0_done_count", dq.size() - nd, 1);
        chk("len0_done_cycle", last_done(), s + 2);
        chk("len0_no_sum", sq.size() - base, 0);

        // reset mid-ACCUM
        arm(12'd10, '0);
        fill_zero();
        base = sq.size();
        nd = dq.size();
        for (int j = 0; j < 3; j++) strobe(rep(8'd1));
        sample_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 3; j++) strobe(rep(8'd1));
        sample_valid = 1'b0;
        repeat (12) tick();
        chk("rstmid_count", sq.size() - base, 2);
        for (int j = 0; j < 2 && base + j < sq.size(); j++)
            chk("rstmid_sum", sq[base+j], 8);
        chk("rstmid_no_done", dq.size() - nd, 0);
        chk("rstmid_busy", busy, 0);

`ifdef BEAMFORMING_RECEIVE_CH_MASK_EN
        // channel mask keeps only ch0 and ch7
        ch_mask = 8'h81;
        arm(12'd3, '0);
        ch_mask = 8'hFF;
        for (int i = 0; i < 31; i++) strobe(rep(8'd5));
        base = sq.size();
        for (int j = 0; j < 3; j++) strobe(rep(8'd5));
        sample_valid = 1'b0;
        wait_done("mask_done_reached");
        tick();
        chk("mask_count", sq.size() - base, 3);
        for (int j = 0; j < 3 && base + j < sq.size(); j++)
            chk("mask_sum", sq[base+j], 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
